// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures a request word and emits the index of each
// set bit, one per valid/ready transfer, highest-first or lowest-first.
module seq_priority_encoder #(
  parameter int WIDTH      = 8,
  parameter int CODE_W     = 3,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  Data,
  input  logic              load,
  output logic              busy,
  output logic [CODE_W-1:0] Code,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              empty_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] rem;

  // Later matches overwrite earlier ones, so the scan direction sets the priority.
  function automatic logic [CODE_W-1:0] pick(input logic [WIDTH-1:0] w);
    logic [CODE_W-1:0] idx;
    idx = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < WIDTH; i++)
        if (w[i]) idx = CODE_W'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (w[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [WIDTH-1:0] w);
    return (w != '0) && ((w & (w - WIDTH'(1))) == '0);
  endfunction

  always_comb begin
    rem = pend & ~(WIDTH'(1) << Code);
  end

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values; the async reset branch clears every register, pend included.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pend      <= '0;
      Code      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      last      <= 1'b0;
      empty_err <= 1'b0;
    end else begin
      empty_err <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            if (Data != '0) begin
              pend  <= Data;
              Code  <= pick(Data);
              last  <= single_bit(Data);
              valid <= 1'b1;
              busy  <= 1'b1;
              state <= EMIT;
            end else begin
              empty_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (ready) begin
            pend <= rem;
            if (rem != '0) begin
              Code <= pick(rem);
              last <= single_bit(rem);
            end else begin
              Code  <= '0;
              last  <= 1'b0;
              valid <= 1'b0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
